exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_pkg.sv | 53 +++++
 rtl/exec_ctrl_alu8.sv | 49 ++++
 rtl/exec_ctrl.sv | 117 +++++++++++
 tb/tb_exec_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the byte-serial execution controller:
// opcode constants, FSM state encoding, instruction-byte layout and
// small opcode classification helpers used by the controller.
package exec_ctrl_pkg;

    localparam int unsigned DW  = 8;
    localparam int unsigned RW  = 2;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_NOP  = 4'h0;
    localparam logic [OPW-1:0] OP_MOV  = 4'h1;
    localparam logic [OPW-1:0] OP_ADD  = 4'h2;
    localparam logic [OPW-1:0] OP_SUB  = 4'h3;
    localparam logic [OPW-1:0] OP_AND  = 4'h4;
    localparam logic [OPW-1:0] OP_OR   = 4'h5;
    localparam logic [OPW-1:0] OP_XOR  = 4'h6;
    localparam logic [OPW-1:0] OP_NOT  = 4'h7;
    localparam logic [OPW-1:0] OP_LDI  = 4'h8;
    localparam logic [OPW-1:0] OP_INC  = 4'h9;
    localparam logic [OPW-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_IMM    = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Instruction byte: opcode, source register, destination register.
    typedef struct packed {
        logic [OPW-1:0] op;
        logic [RW-1:0]  src;
        logic [RW-1:0]  dst;
    } instr_t;

    // Opcodes A..E are reserved.
    function automatic logic is_illegal(input logic [OPW-1:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

    // Arithmetic ops whose carry/borrow lands in cf.
    function automatic logic is_arith(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
    endfunction

    // Logic ops clear cf.
    function automatic logic is_logic(input logic [OPW-1:0] op);
        return (op >= OP_AND) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/exec_ctrl_alu8.sv
// alu8: combinational 8-bit ALU.
//   op     - opcode (exec_ctrl_pkg encoding)
//   a      - destination register value (d)
//   b      - source register value (s)
//   result - 8-bit result, wraps modulo 256
//   carry  - carry out for ADD/INC, borrow for SUB, 0 otherwise
module alu8
    import exec_ctrl_pkg::*;
(
    input  logic [OPW-1:0] op,
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    output logic [DW-1:0]  result,
    output logic           carry
);

    logic [DW:0] wide;

    // 9-bit arithmetic: bit 8 is carry for add, borrow for subtract.
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_MOV: result = b;
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~b;
            OP_INC: begin
                wide   = {1'b0, a} + (DW+1)'(1);
                result = wide[DW-1:0];
                carry  = wide[DW];
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: byte-serial instruction controller driving an external
// four-entry register group.
//   clk, rst          - clock, asynchronous active-high reset
//   instr/instr_valid - incoming instruction or immediate byte
//   instr_ready       - byte accepted on valid & ready at rising edge
//   s, d              - register group read data (selected by raa, rwba)
//   we                - active-low register write strobe (one cycle in WB)
//   raa, rwba         - source and destination register selects
//   i                 - register write data, holds outside WB
//   cf, zf            - carry/borrow and zero flags
//   halted, err       - HALT executed, sticky illegal-opcode flag
module exec_ctrl
    import exec_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [7:0]    s,
    input  logic [7:0]    d,
    output logic          we,
    output logic [1:0]    raa,
    output logic [1:0]    rwba,
    output logic [7:0]    i,
    output logic          cf,
    output logic          zf,
    output logic          halted,
    output logic          err
);

    state_e         state;
    state_e         state_nxt;
    instr_t         ir;
    logic [DW-1:0]  alu_res;
    logic           alu_carry;

    alu8 u_alu (
        .op     (ir.op),
        .a      (d),
        .b      (s),
        .result (alu_res),
        .carry  (alu_carry)
    );

    // Register selects come straight from the latched instruction byte.
    assign raa  = ir.src;
    assign rwba = ir.dst;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (instr_valid) state_nxt = S_DECODE;
            S_DECODE: begin
                if (ir.op == OP_NOP || is_illegal(ir.op)) state_nxt = S_IDLE;
                else if (ir.op == OP_HALT)                state_nxt = S_HALT;
                else if (ir.op == OP_LDI)                 state_nxt = S_IMM;
                else                                      state_nxt = S_EXEC;
            end
            S_IMM:    if (instr_valid) state_nxt = S_WB;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_IDLE;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs; ready is masked by reset so no byte is taken then.
    always_comb begin
        instr_ready = 1'b0;
        we          = 1'b1;
        halted      = 1'b0;
        case (state)
            S_IDLE:  instr_ready = ~rst;
            S_IMM:   instr_ready = ~rst;
            S_WB:    we          = 1'b0;
            S_HALT:  halted      = 1'b1;
            default: ;
        endcase
    end

    // Instruction latch, write data, flags and error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir  <= '0;
            i   <= '0;
            cf  <= 1'b0;
            zf  <= 1'b0;
            err <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   if (instr_valid) ir <= instr_t'(instr);
                S_DECODE: if (is_illegal(ir.op)) err <= 1'b1;
                S_IMM:    if (instr_valid) i <= instr;
                S_EXEC: begin
                    i <= alu_res;
                    if (is_arith(ir.op)) begin
                        cf <= alu_carry;
                        zf <= (alu_res == '0);
                    end else if (is_logic(ir.op)) begin
                        cf <= 1'b0;
                        zf <= (alu_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: behavioural register group, event-scheduled
// reference model, per-cycle compare process, directed and random stimulus.
module tb_exec_ctrl;

    localparam int NEVER = 32'h3fff_ffff;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] s, d;
    logic       we;
    logic [1:0] raa, rwba;
    logic [7:0] i;
    logic       cf, zf, halted, err;

    exec_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .s(s), .d(d), .we(we), .raa(raa),
        .rwba(rwba), .i(i), .cf(cf), .zf(zf), .halted(halted), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External register group: written on the falling edge while we is low.
    logic [7:0] rf [4] = '{default: 8'h00};
    always @(negedge clk) if (!we) rf[rwba] <= i;
    assign s = rf[raa];
    assign d = rf[rwba];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (event schedule per instruction) -------
    int         c        = 0;      // cycle number, bumped at each rising edge
    int         free_cyc = 0;      // first cycle a new instruction may be taken
    int         wb_cyc   = -1;     // cycle in which the write strobe is low
    int         err_at   = -1;
    int         halt_at  = -1;
    int         imm_from = 0;
    bit         imm_wait = 0;
    bit         m_halt = 0, m_err = 0, m_cf = 0, m_zf = 0;
    logic [7:0] m_i = 8'h00, pend_i = 8'h00;
    int         pend_mode = 0;     // 0 flags kept, 1 arithmetic, 2 logic
    bit         pend_c = 0;
    logic [1:0] m_src = 2'd0, m_dst = 2'd0;
    logic [7:0] m_regs [4] = '{default: 8'h00};
    bit         acc = 0;

    function automatic bit m_ready();
        return !rst && !m_halt && ((c >= free_cyc) || (imm_wait && c >= imm_from));
    endfunction

    task automatic model_reset();
        free_cyc = c; wb_cyc = -1; err_at = -1; halt_at = -1;
        imm_wait = 0; m_halt = 0; m_err = 0; m_cf = 0; m_zf = 0;
        m_i = 8'h00; m_src = 2'd0; m_dst = 2'd0;
    endtask

    task automatic model_edge();
        bit r;
        int op, dv, sv, t;
        acc = 0;
        if (rst) begin
            c++;
            model_reset();
            return;
        end
        r = m_ready();
        if (c == wb_cyc) m_regs[m_dst] = m_i;
        c++;
        if (instr_valid && r) begin
            acc = 1;
            if (imm_wait) begin
                imm_wait = 0; pend_i = instr; pend_mode = 0;
                wb_cyc = c; free_cyc = c + 1;
            end else begin
                op = int'(instr[7:4]);
                m_src = instr[3:2];
                m_dst = instr[1:0];
                dv = int'(m_regs[m_dst]);
                sv = int'(m_regs[m_src]);
                pend_c = 0;
                if (op == 0) free_cyc = c + 1;
                else if (op >= 10 && op <= 14) begin err_at = c + 1; free_cyc = c + 1; end
                else if (op == 15) begin halt_at = c + 1; free_cyc = NEVER; end
                else if (op == 8) begin imm_wait = 1; imm_from = c + 1; free_cyc = NEVER; end
                else begin
                    case (op)
                        1: begin pend_i = 8'(sv); pend_mode = 0; end
                        2: begin t = dv + sv; pend_i = 8'(t); pend_c = (t > 255); pend_mode = 1; end
                        3: begin pend_i = 8'(dv - sv); pend_c = (dv < sv); pend_mode = 1; end
                        4: begin pend_i = 8'(dv & sv); pend_mode = 2; end
                        5: begin pend_i = 8'(dv | sv); pend_mode = 2; end
                        6: begin pend_i = 8'(dv ^ sv); pend_mode = 2; end
                        7: begin pend_i = 8'(255 - sv); pend_mode = 2; end
                        default: begin t = dv + 1; pend_i = 8'(t); pend_c = (t > 255); pend_mode = 1; end
                    endcase
                    wb_cyc = c + 2; free_cyc = c + 3;
                end
            end
        end
        if (c == wb_cyc) begin
            m_i = pend_i;
            if (pend_mode == 1) begin m_cf = pend_c; m_zf = (pend_i == 8'h00); end
            if (pend_mode == 2) begin m_cf = 0;      m_zf = (pend_i == 8'h00); end
        end
        if (c == err_at)  m_err  = 1;
        if (c == halt_at) m_halt = 1;
    endtask

    always @(posedge rst) model_reset();

    // Compare process: every cycle, 1 time unit after the rising edge.
    always @(posedge clk) begin
        model_edge();
        #1;
        chk("ready",  32'(instr_ready), 32'(m_ready()));
        chk("we",     32'(we),          32'(c != wb_cyc));
        chk("halted", 32'(halted),      32'(m_halt));
        chk("err",    32'(err),         32'(m_err));
        chk("i",      32'(i),           32'(m_i));
        chk("cf",     32'(cf),          32'(m_cf));
        chk("zf",     32'(zf),          32'(m_zf));
        if (c < free_cyc) begin
            chk("raa",  32'(raa),  32'(m_src));
            chk("rwba", 32'(rwba), 32'(m_dst));
        end
        for (int k = 0; k < 4; k++) chk("reg", 32'(rf[k]), 32'(m_regs[k]));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic send(input logic [7:0] b);
        instr = b; instr_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (acc) begin instr_valid = 1'b0; return; end
        end
        instr_valid = 1'b0;
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic ldi(input logic [1:0] r, input logic [7:0] v);
        send({4'h8, 2'b00, r});
        send(v);
    endtask

    initial begin
        logic [3:0] op4;
        rst = 1'b1; instr = 8'h00; instr_valid = 1'b0;
        step(); step();
        chk("rst_we",    32'(we), 32'd1);
        chk("rst_i",     32'(i),  32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        rst = 1'b0;
        step();

        // LDI A = 0x5A
        send(8'h80);
        send(8'h5A);
        chk("ldi_we",   32'(we),   32'd0);
        chk("ldi_rwba", 32'(rwba), 32'd0);
        chk("ldi_i",    32'(i),    32'h5A);
        step();
        chk("ldi_rega", 32'(rf[0]), 32'h5A);

        // ADD 0x20 + 0xF0
        ldi(2'd1, 8'hF0);
        ldi(2'd0, 8'h20);
        send(8'h24);
        chk("add_ready_dec", 32'(instr_ready), 32'd0);
        step();
        chk("add_we_exec", 32'(we), 32'd1);
        step();
        chk("add_we", 32'(we), 32'd0);
        chk("add_i",  32'(i),  32'h10);
        chk("add_cf", 32'(cf), 32'd1);
        chk("add_zf", 32'(zf), 32'd0);
        step();
        chk("add_ready_after", 32'(instr_ready), 32'd1);

        // SUB equal operands, then 0x10 - 0x20
        ldi(2'd1, 8'h33);
        ldi(2'd2, 8'h33);
        send(8'h36);
        step(); step();
        chk("sub0_i",  32'(i),  32'h00);
        chk("sub0_zf", 32'(zf), 32'd1);
        chk("sub0_cf", 32'(cf), 32'd0);
        ldi(2'd0, 8'h10);
        ldi(2'd1, 8'h20);
        send(8'h34);
        step(); step();
        chk("sub1_i",  32'(i),  32'hF0);
        chk("sub1_cf", 32'(cf), 32'd1);
        chk("sub1_zf", 32'(zf), 32'd0);

        // Reset while in EXEC: instruction abandoned
        send(8'h24);
        step();
        rst = 1'b1;
        #1;
        chk("rx_we",   32'(we),     32'd1);
        chk("rx_i",    32'(i),      32'd0);
        chk("rx_cf",   32'(cf),     32'd0);
        chk("rx_zf",   32'(zf),     32'd0);
        chk("rx_raa",  32'(raa),    32'd0);
        chk("rx_rwba", 32'(rwba),   32'd0);
        chk("rx_halt", 32'(halted), 32'd0);
        chk("rx_err",  32'(err),    32'd0);
        instr = 8'h00; instr_valid = 1'b1;
        step(); step(); step();
        instr_valid = 1'b0;
        rst = 1'b0;
        step();
        ldi(2'd3, 8'h77);
        chk("rx_ldi_i",    32'(i),    32'h77);
        chk("rx_ldi_rwba", 32'(rwba), 32'd3);

        // Random instruction stream (no HALT)
        for (int n = 0; n < 3000; n++) begin
            op4 = 4'($urandom_range(0, 14));
            instr = {op4, 4'($urandom_range(0, 15))};
            instr_valid = 1'($urandom_range(0, 1));
            step();
        end
        instr_valid = 1'b0;
        for (int k = 0; k < 4 && imm_wait; k++) send(8'h00);

        // Illegal opcode
        rst = 1'b1; step(); rst = 1'b0; step();
        send(8'hA0);
        step();
        chk("ill_err",   32'(err),         32'd1);
        chk("ill_we",    32'(we),          32'd1);
        chk("ill_ready", 32'(instr_ready), 32'd1);

        // HALT, then keep offering bytes
        send(8'hF0);
        instr = 8'h24; instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k > 0) begin
                chk("halt_halted", 32'(halted),      32'd1);
                chk("halt_ready",  32'(instr_ready), 32'd0);
                chk("halt_we",     32'(we),          32'd1);
            end
        end
        instr_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
